// File: rtl/grf_write_port.sv
`default_nettype none
// ============================================================================
//  Module   : grf_write_port
//  Purpose  : Write-side arbiter for the general register file. The pipeline
//             W-stage write always has priority. Results from the long-latency
//             auxiliary unit (multiply/divide) wait in a small FIFO and drain
//             into the single GRF write port whenever the pipeline leaves it
//             idle. A busy mask of registers with pending live results lets
//             the hazard unit stall their readers. A starvation counter asks
//             the pipeline to yield once the FIFO head has been blocked for
//             too long.
//
//  Ports    : clk, reset           clock, synchronous active-high reset
//             p_we_i/p_addr_i/p_data_i/p_pc_i
//                                  pipeline W-stage write request
//             x_valid_i/x_addr_i/x_data_i/x_pc_i, x_ready_o
//                                  auxiliary result push handshake
//             reg_write_o/waddr_o/wdata_o/wpc_o
//                                  registered GRF write port (1-cycle latency)
//             busy_mask_o          registers targeted by live FIFO entries
//             stall_req_o          pipeline must hold p_we low next cycle
//             fifo_count_o         current FIFO occupancy
//
//  Revision : 1.0 - initial release
// ============================================================================
module grf_write_port #(
    parameter int DEPTH        = 2,   // FIFO entries, power of two, 2..8
    parameter int STARVE_LIMIT = 4    // blocked cycles before stall_req, 1..15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p_we_i,
    input  logic [4:0]  p_addr_i,
    input  logic [31:0] p_data_i,
    input  logic [31:0] p_pc_i,

    input  logic        x_valid_i,
    output logic        x_ready_o,
    input  logic [4:0]  x_addr_i,
    input  logic [31:0] x_data_i,
    input  logic [31:0] x_pc_i,

    output logic        reg_write_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] wpc_o,

    output logic [31:0] busy_mask_o,
    output logic        stall_req_o,
    output logic [3:0]  fifo_count_o
);

    // ------------------------------------------------------------------------
    // Derived sizes. The count needs DEPTH+1 distinct values so that a full
    // FIFO is distinguishable from an empty one with equal pointers.
    // ------------------------------------------------------------------------
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam int              CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [3:0]       STARVE_C = 4'(STARVE_LIMIT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       starve_q;

    logic             reg_write_q;
    logic [4:0]       waddr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      wpc_q;

    // Next-state
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [DEPTH-1:0] live_d;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0] count_d;
    logic [3:0]       starve_d;

    logic             reg_write_d;
    logic [4:0]       waddr_d;
    logic [31:0]      wdata_d;
    logic [31:0]      wpc_d;

    // ------------------------------------------------------------------------
    // Handshake and arbitration decisions
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_push;
    logic w_p_issue;
    logic w_pop;
    logic w_head_live;

    // A full FIFO refuses pushes even if a pop happens in the same cycle; this
    // keeps x_ready independent of the pipeline request.
    assign x_ready_o   = (count_q < DEPTH_C) && !reset;
    assign w_empty     = (count_q == '0);
    assign w_push      = x_valid_i && x_ready_o;

    // Writes to $0 are discarded outright so they never steal a drain slot.
    assign w_p_issue   = p_we_i && (p_addr_i != 5'd0);
    assign w_pop       = !w_p_issue && !w_empty;
    assign w_head_live = live_q[rd_ptr_q];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        pc_d        = pc_q;
        live_d      = live_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        starve_d    = starve_q;
        reg_write_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wpc_d       = wpc_q;

        // Write port selection: pipeline first, then a live FIFO head.
        if (w_p_issue) begin
            reg_write_d = 1'b1;
            waddr_d     = p_addr_i;
            wdata_d     = p_data_i;
            wpc_d       = p_pc_i;
        end else if (w_pop && w_head_live) begin
            reg_write_d = 1'b1;
            waddr_d     = addr_q[rd_ptr_q];
            wdata_d     = data_q[rd_ptr_q];
            wpc_d       = pc_q[rd_ptr_q];
        end

        // A pipeline write to A is younger than every stored result for A,
        // so those results must never reach the GRF. Stored entries only;
        // the same-cycle push below is applied afterwards and stays live.
        if (w_p_issue) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i] && (addr_q[i] == p_addr_i)) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        // Popped slots are marked dead so busy_mask can scan every slot
        // without needing to know which ones are occupied.
        if (w_pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        // The push slot never coincides with the pop slot: a push needs
        // count < DEPTH, and a pop needs count > 0.
        if (w_push) begin
            addr_d[wr_ptr_q] = x_addr_i;
            data_d[wr_ptr_q] = x_data_i;
            pc_d[wr_ptr_q]   = x_pc_i;
            live_d[wr_ptr_q] = (x_addr_i != 5'd0);
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

        // Count consecutive cycles in which the head was held off.
        if (w_empty || w_pop) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_C) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
                pc_q[i]   <= 32'd0;
            end
            live_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= 4'd0;
            reg_write_q <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
            wpc_q       <= 32'd0;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            pc_q        <= pc_d;
            live_q      <= live_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wpc_q       <= wpc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Busy mask: one-hot decode of every live slot, ORed together. $0 is
    // never a hazard, and dead entries are already filtered by live_q.
    // ------------------------------------------------------------------------
    logic [31:0] w_slot_dec [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot_dec
        assign w_slot_dec[g] = live_q[g] ? (32'd1 << addr_q[g]) : 32'd0;
    end

    always_comb begin
        busy_mask_o = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask_o = busy_mask_o | w_slot_dec[i];
        end
        busy_mask_o[0] = 1'b0;
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign reg_write_o  = reg_write_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign wpc_o        = wpc_q;
    assign stall_req_o  = (starve_q == STARVE_C);
    assign fifo_count_o = 4'(count_q);

endmodule
`default_nettype wire

// File: tb/tb_grf_write_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grf_write_port
//  Purpose  : Directed vector bench for grf_write_port: a table of per-cycle
//             stimulus with hand-computed post-edge outputs, followed by a
//             hand-written reset-during-drain sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grf_write_port;

    logic        clk;
    logic        reset;
    logic        p_we_i;
    logic [4:0]  p_addr_i;
    logic [31:0] p_data_i;
    logic [31:0] p_pc_i;
    logic        x_valid_i;
    logic        x_ready_o;
    logic [4:0]  x_addr_i;
    logic [31:0] x_data_i;
    logic [31:0] x_pc_i;
    logic        reg_write_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic [31:0] wpc_o;
    logic [31:0] busy_mask_o;
    logic        stall_req_o;
    logic [3:0]  fifo_count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] grf [32];

    grf_write_port #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p_we_i       (p_we_i),
        .p_addr_i     (p_addr_i),
        .p_data_i     (p_data_i),
        .p_pc_i       (p_pc_i),
        .x_valid_i    (x_valid_i),
        .x_ready_o    (x_ready_o),
        .x_addr_i     (x_addr_i),
        .x_data_i     (x_data_i),
        .x_pc_i       (x_pc_i),
        .reg_write_o  (reg_write_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .wpc_o        (wpc_o),
        .busy_mask_o  (busy_mask_o),
        .stall_req_o  (stall_req_o),
        .fifo_count_o (fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic [31:0] pp;
        logic        xv;
        logic [4:0]  xa;
        logic [31:0] xd;
        logic [31:0] xp;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] wp;
        logic [31:0] bm;
        logic        st;
        logic [3:0]  cnt;
        logic        xr;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic we, input logic [4:0] pa, input logic [31:0] pd, input logic [31:0] pp,
        input logic xv, input logic [4:0] xa, input logic [31:0] xd, input logic [31:0] xp,
        input logic rw, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] wp,
        input logic [31:0] bm, input logic st, input logic [3:0] cnt, input logic xr);
        vec_t v;
        v.we = we; v.pa = pa; v.pd = pd; v.pp = pp;
        v.xv = xv; v.xa = xa; v.xd = xd; v.xp = xp;
        v.rw = rw; v.wa = wa; v.wd = wd; v.wp = wp;
        v.bm = bm; v.st = st; v.cnt = cnt; v.xr = xr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] pa, input logic [31:0] pd,
                         input logic [31:0] pp, input logic xv, input logic [4:0] xa,
                         input logic [31:0] xd, input logic [31:0] xp);
        p_we_i = we; p_addr_i = pa; p_data_i = pd; p_pc_i = pp;
        x_valid_i = xv; x_addr_i = xa; x_data_i = xd; x_pc_i = xp;
    endtask

    // Advance one clock and sample 1ns after the edge; mirror GRF writes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (reg_write_o === 1'b1) grf[waddr_o] = wdata_o;
    endtask

    task automatic chk_all(input string tag, input logic rw, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [31:0] wp, input logic [31:0] bm,
                           input logic st, input logic [3:0] cnt, input logic xr);
        chk({tag, ".reg_write"},  32'(reg_write_o),  32'(rw));
        chk({tag, ".waddr"},      32'(waddr_o),      32'(wa));
        chk({tag, ".wdata"},      wdata_o,           wd);
        chk({tag, ".wpc"},        wpc_o,             wp);
        chk({tag, ".busy_mask"},  busy_mask_o,       bm);
        chk({tag, ".stall_req"},  32'(stall_req_o),  32'(st));
        chk({tag, ".fifo_count"}, 32'(fifo_count_o), 32'(cnt));
        chk({tag, ".x_ready"},    32'(x_ready_o),    32'(xr));
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(tbl[i].we, tbl[i].pa, tbl[i].pd, tbl[i].pp,
                  tbl[i].xv, tbl[i].xa, tbl[i].xd, tbl[i].xp);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].rw, tbl[i].wa, tbl[i].wd, tbl[i].wp,
                    tbl[i].bm, tbl[i].st, tbl[i].cnt, tbl[i].xr);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) grf[r] = 32'd0;

        // ---------------- stimulus table ----------------
        //             we pa  pd          pp        xv xa xd      xp        rw wa  wd          wp        bm      st cnt xr
        // pipeline only
        tbl[0]  = mk(1, 5,  32'h1234, 32'h3000, 0, 0, 0,      0,        1, 5,  32'h1234, 32'h3000, 32'h0,   0, 0, 1);
        tbl[1]  = mk(0, 0,  0,        0,        0, 0, 0,      0,        0, 5,  32'h1234, 32'h3000, 32'h0,   0, 0, 1);
        // aux fill ($20 pipeline write holds the head so count reaches 2) and drain
        tbl[2]  = mk(0, 0,  0,        0,        1, 8, 32'hA,  32'h100,  0, 5,  32'h1234, 32'h3000, 32'h100, 0, 1, 1);
        tbl[3]  = mk(1, 20, 32'h55,   32'h200,  1, 9, 32'hB,  32'h104,  1, 20, 32'h55,   32'h200,  32'h300, 0, 2, 0);
        tbl[4]  = mk(0, 0,  0,        0,        0, 0, 0,      0,        1, 8,  32'hA,    32'h100,  32'h200, 0, 1, 1);
        tbl[5]  = mk(0, 0,  0,        0,        0, 0, 0,      0,        1, 9,  32'hB,    32'h104,  32'h0,   0, 0, 1);
        tbl[6]  = mk(0, 0,  0,        0,        0, 0, 0,      0,        0, 9,  32'hB,    32'h104,  32'h0,   0, 0, 1);
        // starvation: $3 held off by pipeline writes to $4, saturates, then drains
        tbl[7]  = mk(0, 0,  0,        0,        1, 3, 32'h33, 32'h300,  0, 9,  32'hB,    32'h104,  32'h8,   0, 1, 1);
        tbl[8]  = mk(1, 4,  32'h40,   32'h400,  0, 0, 0,      0,        1, 4,  32'h40,   32'h400,  32'h8,   0, 1, 1);
        tbl[9]  = mk(1, 4,  32'h41,   32'h404,  0, 0, 0,      0,        1, 4,  32'h41,   32'h404,  32'h8,   0, 1, 1);
        tbl[10] = mk(1, 4,  32'h42,   32'h408,  0, 0, 0,      0,        1, 4,  32'h42,   32'h408,  32'h8,   0, 1, 1);
        tbl[11] = mk(1, 4,  32'h43,   32'h40C,  0, 0, 0,      0,        1, 4,  32'h43,   32'h40C,  32'h8,   1, 1, 1);
        tbl[12] = mk(1, 4,  32'h44,   32'h410,  0, 0, 0,      0,        1, 4,  32'h44,   32'h410,  32'h8,   1, 1, 1);
        tbl[13] = mk(0, 0,  0,        0,        0, 0, 0,      0,        1, 3,  32'h33,   32'h300,  32'h0,   0, 0, 1);
        tbl[14] = mk(0, 0,  0,        0,        0, 0, 0,      0,        0, 3,  32'h33,   32'h300,  32'h0,   0, 0, 1);
        // squash: stored $7=1 killed by pipeline $7=2, dead pop issues nothing
        tbl[15] = mk(0, 0,  0,        0,        1, 7, 32'h1,  32'h700,  0, 3,  32'h33,   32'h300,  32'h80,  0, 1, 1);
        tbl[16] = mk(1, 7,  32'h2,    32'h704,  0, 0, 0,      0,        1, 7,  32'h2,    32'h704,  32'h0,   0, 1, 1);
        tbl[17] = mk(0, 0,  0,        0,        0, 0, 0,      0,        0, 7,  32'h2,    32'h704,  32'h0,   0, 0, 1);
        // same-cycle push to $7 is younger and survives the pipeline $7 write
        tbl[18] = mk(1, 7,  32'h3,    32'h708,  1, 7, 32'h9,  32'h70C,  1, 7,  32'h3,    32'h708,  32'h80,  0, 1, 1);
        tbl[19] = mk(0, 0,  0,        0,        0, 0, 0,      0,        1, 7,  32'h9,    32'h70C,  32'h0,   0, 0, 1);
        // $0 filtering
        tbl[20] = mk(1, 0,  32'hDEAD, 32'h800,  0, 0, 0,      0,        0, 7,  32'h9,    32'h70C,  32'h0,   0, 0, 1);
        tbl[21] = mk(0, 0,  0,        0,        1, 0, 32'hEE, 32'h804,  0, 7,  32'h9,    32'h70C,  32'h0,   0, 1, 1);
        tbl[22] = mk(1, 0,  32'hDEAD, 32'h808,  0, 0, 0,      0,        0, 7,  32'h9,    32'h70C,  32'h0,   0, 0, 1);

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // ---------------- table ----------------
        run_rows(0, 17);
        chk("squash.grf7", grf[7], 32'h2);
        run_rows(18, NVEC - 1);

        // ---------------- reset mid-drain ----------------
        drive(1, 21, 32'h21, 32'h904, 1, 10, 32'hAA, 32'h900);
        tick();
        chk_all("rst.fill1", 1, 21, 32'h21, 32'h904, 32'h400, 0, 1, 1);
        drive(1, 21, 32'h22, 32'h90C, 1, 11, 32'hBB, 32'h908);
        tick();
        chk_all("rst.fill2", 1, 21, 32'h22, 32'h90C, 32'hC00, 0, 2, 0);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("rst.during", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk_all("rst.after1", 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rst.idle%0d.reg_write", k), 32'(reg_write_o), 32'd0);
            chk($sformatf("rst.idle%0d.fifo_count", k), 32'(fifo_count_o), 32'd0);
        end
        chk("rst.grf10", grf[10], 32'h0);
        chk("rst.grf11", grf[11], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
